// File: rtl/stopwatch_controller.sv
`default_nettype none
// ============================================================================
// Module      : stopwatch_controller
// Description : Start/stop/clear sequencing and 1 Hz tick generation for an
//               MM:SS stopwatch with sticky wrap-around (overflow) flag.
// Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_controller #(
    parameter int TICK_DIV = 4,
    parameter int SEC_MAX  = 59,
    parameter int MIN_MAX  = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic [5:0] seconds,
    input  logic [7:0] minutes,
    output logic       sec_en,
    output logic       min_en,
    output logic       cnt_clr,
    output logic       running,
    output logic       paused,
    output logic       overflow
);

    localparam int              c_pw        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_pw-1:0] c_presc_max = c_pw'(TICK_DIV - 1);
    localparam logic [5:0]      c_sec_max   = 6'(SEC_MAX);
    localparam logic [7:0]      c_min_max   = 8'(MIN_MAX);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [c_pw-1:0] r_presc;
    logic [c_pw-1:0] w_presc_nxt;
    logic            r_start_d;
    logic            r_stop_d;
    logic            r_clear_d;
    logic            r_cnt_clr;
    logic            r_overflow;
    logic            w_start_edge;
    logic            w_stop_edge;
    logic            w_clear_edge;

    assign w_start_edge = start & ~r_start_d;
    assign w_stop_edge  = stop  & ~r_stop_d;
    assign w_clear_edge = clear & ~r_clear_d;

    assign running  = (r_state == ST_RUNNING);
    assign paused   = (r_state == ST_PAUSED);
    assign sec_en   = running && (r_presc == c_presc_max);
    assign min_en   = sec_en && (seconds == c_sec_max);
    assign cnt_clr  = r_cnt_clr;
    assign overflow = r_overflow;

    // Clear beats stop beats start; a simultaneous start+stop never starts.
    always_comb begin
        w_state_nxt = r_state;
        if (w_clear_edge) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    if (w_start_edge && !w_stop_edge) w_state_nxt = ST_RUNNING;
                ST_RUNNING: if (w_stop_edge)                  w_state_nxt = ST_PAUSED;
                ST_PAUSED:  if (w_start_edge && !w_stop_edge) w_state_nxt = ST_RUNNING;
                default:                                      w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Prescaler advances on every RUNNING cycle, including the one carrying a
    // stop edge, so a pause freezes the phase reached and resume loses nothing.
    always_comb begin
        w_presc_nxt = r_presc;
        if (w_clear_edge || (r_state == ST_IDLE)) begin
            w_presc_nxt = '0;
        end else if (r_state == ST_RUNNING) begin
            w_presc_nxt = (r_presc == c_presc_max) ? '0 : r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_presc    <= '0;
            r_start_d  <= 1'b0;
            r_stop_d   <= 1'b0;
            r_clear_d  <= 1'b0;
            r_cnt_clr  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_presc_nxt;
            r_start_d  <= start;
            r_stop_d   <= stop;
            r_clear_d  <= clear;
            r_cnt_clr  <= w_clear_edge;
            if (w_clear_edge) begin
                r_overflow <= 1'b0;
            end else if (min_en && (minutes == c_min_max)) begin
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_stopwatch_controller
// Description : Directed self-checking bench for stopwatch_controller
//               (TICK_DIV=4, SEC_MAX=59, MIN_MAX=99).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       clear;
    logic [5:0] seconds;
    logic [7:0] minutes;
    logic       sec_en;
    logic       min_en;
    logic       cnt_clr;
    logic       running;
    logic       paused;
    logic       overflow;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_controller #(
        .TICK_DIV (4),
        .SEC_MAX  (59),
        .MIN_MAX  (99)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .seconds  (seconds),
        .minutes  (minutes),
        .sec_en   (sec_en),
        .min_en   (min_en),
        .cnt_clr  (cnt_clr),
        .running  (running),
        .paused   (paused),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Registered outputs of the edge just taken are visible 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        seconds = 6'd0; minutes = 8'd0;

        // Reset state
        step(); step();
        check_eq("rst_running",  running,  1'b0);
        check_eq("rst_paused",   paused,   1'b0);
        check_eq("rst_sec_en",   sec_en,   1'b0);
        check_eq("rst_min_en",   min_en,   1'b0);
        check_eq("rst_overflow", overflow, 1'b0);
        check_eq("rst_cnt_clr",  cnt_clr,  1'b0);
        rst = 1'b0;
        step();
        check_eq("idle_running", running, 1'b0);

        // Start edge; start then held high. Ticks on running cycles 4, 8, 12.
        start = 1'b1;
        step();
        check_eq("start_running", running, 1'b1);
        for (int i = 1; i <= 14; i++) begin
            check_eq($sformatf("run_sec_en_c%0d", i), sec_en, ((i % 4) == 0) ? 1'b1 : 1'b0);
            check_eq($sformatf("run_held_c%0d", i), running, 1'b1);
            if (i < 14) step();
        end
        // Running cycle 14 has prescaler 1; stop edge there pauses at phase 2.
        stop = 1'b1;
        step();
        check_eq("stop_paused",  paused,  1'b1);
        check_eq("stop_running", running, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step();
            check_eq($sformatf("pause_sec_en_%0d", i), sec_en, 1'b0);
            check_eq($sformatf("pause_hold_%0d", i), paused, 1'b1);
        end

        // Resume: two more running cycles complete the interrupted tick.
        start = 1'b0;
        step();
        check_eq("resume_prep_paused", paused, 1'b1);
        start = 1'b1;
        step();
        check_eq("resume_running", running, 1'b1);
        check_eq("resume_sec_en_0", sec_en, 1'b0);
        step();
        check_eq("resume_sec_en_1", sec_en, 1'b1);

        // min_en follows seconds combinationally in a sec_en cycle
        seconds = 6'd59;
        #1;
        check_eq("min_en_sec59", min_en, 1'b1);
        seconds = 6'd58;
        #1;
        check_eq("min_en_sec58", min_en, 1'b0);

        // Overflow at 99:59 on the next tick (4 cycles later)
        step();
        seconds = 6'd59; minutes = 8'd99;
        for (int i = 1; i <= 3; i++) begin
            #1;
            check_eq($sformatf("ovf_wait_sec_en_%0d", i), sec_en, 1'b0);
            check_eq($sformatf("ovf_wait_flag_%0d", i), overflow, 1'b0);
            step();
        end
        #1;
        check_eq("ovf_tick_min_en", min_en,   1'b1);
        check_eq("ovf_tick_flag",   overflow, 1'b0);
        step();
        seconds = 6'd0; minutes = 8'd0;
        check_eq("ovf_set", overflow, 1'b1);
        check_eq("ovf_still_running", running, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq($sformatf("ovf_sticky_%0d", i), overflow, 1'b1);
        end

        // Clear edge (clear held high afterwards): one cnt_clr, overflow drops, IDLE
        clear = 1'b1;
        step();
        check_eq("clr_cnt_clr",  cnt_clr,  1'b1);
        check_eq("clr_overflow", overflow, 1'b0);
        check_eq("clr_running",  running,  1'b0);
        check_eq("clr_paused",   paused,   1'b0);
        step();
        check_eq("clr_cnt_clr_once", cnt_clr, 1'b0);
        step();
        check_eq("clr_held_no_pulse", cnt_clr, 1'b0);

        // Simultaneous start+stop edges in IDLE: stays IDLE
        clear = 1'b0; start = 1'b0; stop = 1'b0;
        step();
        start = 1'b1; stop = 1'b1;
        step();
        check_eq("both_idle_running", running, 1'b0);
        check_eq("both_idle_paused",  paused,  1'b0);

        // Simultaneous start+stop edges in RUNNING: PAUSED
        start = 1'b0; stop = 1'b0;
        step();
        start = 1'b1;
        step();
        check_eq("both_run_prep", running, 1'b1);
        start = 1'b0;
        step();
        start = 1'b1; stop = 1'b1;
        step();
        check_eq("both_run_paused",  paused,  1'b1);
        check_eq("both_run_running", running, 1'b0);

        // Resume at prescaler 2, then reset mid-run
        start = 1'b0; stop = 1'b0;
        step();
        start = 1'b1;
        step();
        check_eq("pre_rst_running", running, 1'b1);
        check_eq("pre_rst_sec_en",  sec_en,  1'b0);
        rst = 1'b1; seconds = 6'd59; minutes = 8'd99;
        step();
        check_eq("mid_rst_running", running, 1'b0);
        check_eq("mid_rst_paused",  paused,  1'b0);
        check_eq("mid_rst_sec_en",  sec_en,  1'b0);
        check_eq("mid_rst_min_en",  min_en,  1'b0);
        rst = 1'b0; start = 1'b0; seconds = 6'd0; minutes = 8'd0;
        step();
        check_eq("post_rst_sec_en", sec_en, 1'b0);
        // A fresh start must tick on the 4th running cycle (prescaler restarted)
        start = 1'b1;
        step();
        for (int i = 1; i <= 4; i++) begin
            check_eq($sformatf("post_rst_tick_c%0d", i), sec_en, (i == 4) ? 1'b1 : 1'b0);
            if (i < 4) step();
        end

        // Clear beats stop while RUNNING
        clear = 1'b1; stop = 1'b1;
        step();
        check_eq("clr_vs_stop_running", running, 1'b0);
        check_eq("clr_vs_stop_paused",  paused,  1'b0);
        check_eq("clr_vs_stop_cnt_clr", cnt_clr, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_controller.md
STOPWATCH_CONTROLLER -- requirements
Module: stopwatch_controller

Interface
REQ-001 Parameter TICK_DIV, default 4, clk cycles per one-second tick; legal values >= 2.
REQ-002 Parameter SEC_MAX, default 59, terminal value of the seconds counter.
REQ-003 Parameter MIN_MAX, default 99, terminal value of the minutes counter.
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 start  in  1  level input from the button; rising edge requests run.
REQ-007 stop  in  1  level input; rising edge requests pause.
REQ-008 clear  in  1  level input; rising edge requests clear to 00:00.
REQ-009 seconds  in  6  current seconds counter value.
REQ-010 minutes  in  8  current minutes counter value.
REQ-011 sec_en  out  1  one-cycle enable to the seconds counter.
REQ-012 min_en  out  1  one-cycle enable to the minutes counter.
REQ-013 cnt_clr  out  1  one-cycle synchronous clear to both counters.
REQ-014 running  out  1  high in RUNNING.
REQ-015 paused  out  1  high in PAUSED.
REQ-016 overflow  out  1  sticky; time wrapped past MIN_MAX:SEC_MAX.

Function
REQ-017 Edge detect: the block shall register start/stop/clear; an edge is (input=1, previous sample=0); a held level shall produce one edge only.
REQ-018 FSM states IDLE, RUNNING, PAUSED; the state register shall update one cycle after the detected edge.
REQ-019 IDLE: start edge -> RUNNING; stop edge ignored.
REQ-020 RUNNING: stop edge -> PAUSED; start edge ignored.
REQ-021 PAUSED: start edge -> RUNNING; stop edge ignored.
REQ-022 Clear edge, any state -> IDLE; priority clear > stop > start.
REQ-023 Start and stop edges in the same cycle: stop wins (RUNNING -> PAUSED; IDLE and PAUSED unchanged).
REQ-024 Prescaler, width $clog2(TICK_DIV): increments only in RUNNING, wraps TICK_DIV-1 -> 0, holds in PAUSED, zeroed on clear edge and in IDLE.
REQ-025 sec_en = (state==RUNNING) && (prescaler==TICK_DIV-1), combinational from registers; exactly one pulse per TICK_DIV running cycles.
REQ-026 min_en = sec_en && (seconds==SEC_MAX).
REQ-027 overflow shall set the cycle after min_en && (minutes==MIN_MAX), hold until clear edge or rst, and not stop counting (counters wrap to 00:00).
REQ-028 cnt_clr shall be a registered one-cycle pulse asserted in the cycle after a clear edge; overflow shall clear in that same cycle.
REQ-029 A stop edge coinciding with a sec_en cycle: that sec_en still issues; the prescaler then holds at 0 in PAUSED.
REQ-030 Resume from PAUSED continues from the held prescaler value, with no lost or extra ticks.
REQ-031 A clear edge coinciding with sec_en: the pulse may issue; overflow set from that cycle is suppressed; the following cnt_clr forces 00:00.

Reset
REQ-032 While rst=1 at posedge clk: state=IDLE, prescaler=0, overflow=0, cnt_clr=0, edge registers=0.
REQ-033 Consequently running=0, paused=0, sec_en=0, min_en=0 from the first cycle after rst.
REQ-034 Reset mid-operation shall abort any state immediately; the counters are not cleared by this block on rst.

Verification (TICK_DIV=4, SEC_MAX=59, MIN_MAX=99)
REQ-035 rst 2 cycles, start edge -> running=1 next cycle; sec_en on 4th running cycle and every 4 cycles after.
REQ-036 Held start high for 20 cycles, then stop edge -> single transition only; paused=1; no sec_en while paused; resume preserves phase.
REQ-037 seconds=59 at sec_en -> min_en=1 same cycle; seconds=58 -> min_en=0.
REQ-038 minutes=99, seconds=59, sec_en -> overflow=1 next cycle, stays 1 until clear edge; cnt_clr=1 for exactly one cycle, then overflow=0, IDLE.
REQ-039 Start and stop edges same cycle in RUNNING -> PAUSED; in IDLE -> stays IDLE.
REQ-040 rst asserted while RUNNING with prescaler=2 -> next cycle running=0, prescaler=0, no sec_en.
